bcd_adder: RTL and testbench

- Registered multi-digit packed-BCD adder. Computes S = A + B + Cin in decimal, with a decimal carry out.
- Default configuration is 2 digits (8-bit operands, range 00..99).
- Intended as an arithmetic leaf inside decimal datapaths such as counters, display accumulators and checksum units.
- Result is registered with one-cycle latency and a simple valid strobe.

---
 rtl/bcd_adder.sv | 79 +++++++
 tb/tb_bcd_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_adder.sv
// rtl/bcd_adder.sv - registered packed-BCD ripple adder, S = A + B + Cin, one-cycle latency.
// Define BCD_ADDER_INVALID_FLAG_EN to add the registered 'invalid' nibble-range flag.
module bcd_adder #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
  output logic [4*DIGITS-1:0] S,
  output logic                Cout,
  output logic                out_valid
`ifdef BCD_ADDER_INVALID_FLAG_EN
  ,
  output logic                invalid
`endif
);

  localparam int W = 4 * DIGITS;

  logic [DIGITS:0] carry;
  logic [W-1:0]    sum_c;
  logic [4:0]      t;

  // Decimal ripple: a digit above 9 is corrected by +6 and pushes a carry upward.
  // Non-BCD nibbles go through the same formula, so results stay deterministic.
  always_comb begin
    carry    = '0;
    sum_c    = '0;
    t        = '0;
    carry[0] = Cin;
    for (int i = 0; i < DIGITS; i++) begin
      t = {1'b0, A[4*i +: 4]} + {1'b0, B[4*i +: 4]} + {4'b0000, carry[i]};
      if (t > 5'd9) begin
        sum_c[4*i +: 4] = t[3:0] + 4'd6;
        carry[i+1]      = 1'b1;
      end else begin
        sum_c[4*i +: 4] = t[3:0];
        carry[i+1]      = 1'b0;
      end
    end
  end

`ifdef BCD_ADDER_INVALID_FLAG_EN
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef BCD_ADDER_INVALID_FLAG_EN
      invalid   <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S       <= sum_c;
        Cout    <= carry[DIGITS];
`ifdef BCD_ADDER_INVALID_FLAG_EN
        invalid <= bad_digit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_adder.sv
// tb/tb_bcd_adder.sv - directed-vector bench for bcd_adder with a per-digit decimal model.
// Covers the optional invalid flag when BCD_ADDER_INVALID_FLAG_EN is defined.
module tb_bcd_adder;

  localparam int DIGITS = 2;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] S;
  logic         Cout;
  logic         out_valid;
  logic         invalid_q;

  bcd_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid)
`ifdef BCD_ADDER_INVALID_FLAG_EN
    ,
    .invalid   (invalid_q)
`endif
  );

`ifndef BCD_ADDER_INVALID_FLAG_EN
  assign invalid_q = 1'b0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: what the registered outputs must hold after each edge.
  logic [W-1:0] exp_s    = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ov   = 1'b0;
  logic         exp_inv  = 1'b0;

  // Literal expectation attached to the vector being driven this cycle.
  logic         lit_en   = 1'b0;
  logic [W-1:0] lit_s    = '0;
  logic         lit_cout = 1'b0;
  logic         lit_ov   = 1'b0;
  logic         lit_inv  = 1'b0;
  string        lit_name = "";

  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    int c;
    int t;
    logic [W-1:0] s;
    c = int'(cin);
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (t > 9) begin
        s[4*i +: 4] = 4'((t + 6) % 16);
        c = 1;
      end else begin
        s[4*i +: 4] = 4'(t);
        c = 0;
      end
    end
    return {c[0], s};
  endfunction

  function automatic logic model_invalid(input logic [W-1:0] a, input logic [W-1:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(a[4*i +: 4]) > 9 || int'(b[4*i +: 4]) > 9) r = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Single compare process: advance the model on each edge, check 1 time unit later.
  always @(posedge clk) begin
    logic [W:0] r;
    if (rst) begin
      exp_s    = '0;
      exp_cout = 1'b0;
      exp_ov   = 1'b0;
      exp_inv  = 1'b0;
    end else begin
      exp_ov = in_valid;
      if (in_valid) begin
        r        = model_add(A, B, Cin);
        exp_s    = r[W-1:0];
        exp_cout = r[W];
        exp_inv  = model_invalid(A, B);
      end
    end
    #1;
    check("model_s", 32'(S), 32'(exp_s));
    check("model_cout", 32'(Cout), 32'(exp_cout));
    check("model_out_valid", 32'(out_valid), 32'(exp_ov));
`ifdef BCD_ADDER_INVALID_FLAG_EN
    check("model_invalid", 32'(invalid_q), 32'(exp_inv));
`endif
    if (lit_en) begin
      check({lit_name, "_s"}, 32'(S), 32'(lit_s));
      check({lit_name, "_cout"}, 32'(Cout), 32'(lit_cout));
      check({lit_name, "_out_valid"}, 32'(out_valid), 32'(lit_ov));
`ifdef BCD_ADDER_INVALID_FLAG_EN
      check({lit_name, "_invalid"}, 32'(invalid_q), 32'(lit_inv));
`endif
    end
  end

  // Drive one cycle of inputs at the falling edge, with the result expected after the next edge.
  task automatic drive(input string name, input logic r, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic [W-1:0] es,
                       input logic ec, input logic eov, input logic einv);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = cin;
    lit_en   = 1'b1;
    lit_name = name;
    lit_s    = es;
    lit_cout = ec;
    lit_ov   = eov;
    lit_inv  = einv;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    A        = 8'h55;
    B        = 8'h44;
    Cin      = 1'b0;
    lit_en   = 1'b1;
    lit_name = "reset0";

    drive("reset1",     1, 1, 8'h55, 8'h44, 0, 8'h00, 0, 0, 0);
    drive("basic",      0, 1, 8'h01, 8'h01, 0, 8'h02, 0, 1, 0);
    drive("carry_9_9",  0, 1, 8'h09, 8'h09, 1, 8'h19, 0, 1, 0);
    drive("carry_10_1", 0, 1, 8'h10, 8'h01, 0, 8'h11, 0, 1, 0);
    drive("multi",      0, 1, 8'h41, 8'h11, 0, 8'h52, 0, 1, 0);
    drive("idle_hold",  0, 0, 8'h77, 8'h88, 1, 8'h52, 0, 0, 0);
    drive("multi2",     0, 1, 8'h41, 8'h11, 0, 8'h52, 0, 1, 0);
    drive("full_scale", 0, 1, 8'h99, 8'h99, 1, 8'h99, 1, 1, 0);
    drive("idle_full",  0, 0, 8'h00, 8'h00, 0, 8'h99, 1, 0, 0);
    drive("non_bcd",    0, 1, 8'h0F, 8'h0F, 1, 8'h15, 0, 1, 1);
    drive("after_bad",  0, 1, 8'h12, 8'h34, 0, 8'h46, 0, 1, 0);
    drive("wrap_50_50", 0, 1, 8'h50, 8'h50, 0, 8'h00, 1, 1, 0);
    drive("cin_only",   0, 1, 8'h00, 8'h00, 1, 8'h01, 0, 1, 0);
    drive("ripple_2d",  0, 1, 8'h95, 8'h04, 1, 8'h00, 1, 1, 0);
    drive("hi_bad",     0, 1, 8'hA0, 8'h00, 0, 8'h00, 1, 1, 1);
    drive("rst_mid",    1, 1, 8'h99, 8'h99, 1, 8'h00, 0, 0, 0);
    drive("post_rst",   0, 1, 8'h37, 8'h48, 0, 8'h85, 0, 1, 0);
    drive("idle_end",   0, 0, 8'h00, 8'h00, 0, 8'h85, 0, 0, 0);

    @(negedge clk);
    lit_en = 1'b0;
    // Broader model-only sweep over legal BCD operands.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = (i % 5) != 4;
      A        = {4'(i % 10), 4'((i * 7) % 10)};
      B        = {4'((i * 3) % 10), 4'((i + 9) % 10)};
      Cin      = 1'(i % 2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
